// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Raster timing bundle from the VGA timing generator to the pixel-stage
//   consumers (colour bar, pattern, framebuffer readers).
//
//   Flow control: the raster stream has no valid/ready handshake. Every
//   pixel-clock cycle carries exactly one pixel slot. Consumers cannot apply
//   backpressure. They qualify pixel data with DISPLAY and use LINE_START and
//   FRAME_START to realign.
//
//   Signals (master drives, slave observes):
//     X, Y         pixel coordinate of the current slot. The coordinate stays
//                  valid in blanking as well.
//     HSYNC/VSYNC  sync levels. The polarity is set by the generator parameters.
//     DISPLAY      high when (X,Y) lies inside the active area.
//     LINE_START   pulse on X==0 of every line.
//     FRAME_START  pulse on X==0, Y==0.
//     h_phase      debug view of the horizontal FSM state at the counter stage,
//                  one cycle ahead of X.
//     v_phase      debug view of the vertical FSM state at the counter stage,
//                  one cycle ahead of X.
interface vga_timing_gen_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10
);
  logic [X_WIDTH-1:0] X;
  logic [Y_WIDTH-1:0] Y;
  logic               HSYNC;
  logic               VSYNC;
  logic               DISPLAY;
  logic               LINE_START;
  logic               FRAME_START;
  logic [1:0]         h_phase;
  logic [1:0]         v_phase;

  modport master (
    output X, Y, HSYNC, VSYNC, DISPLAY, LINE_START, FRAME_START, h_phase, v_phase
  );

  modport slave (
    input X, Y, HSYNC, VSYNC, DISPLAY, LINE_START, FRAME_START, h_phase, v_phase
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing generator. Horizontal and vertical counters
//   run through ACTIVE -> FRONT -> SYNC -> BACK. A pair of phase FSMs tracks
//   these counters. All raster outputs are registered from the same counter
//   and FSM snapshot, so they always describe the same pixel.
//
//   Ports:
//     pixel_clk  pixel clock; all logic runs on the rising edge.
//     reset      synchronous, active-high.
//     vga        vga_timing_gen_if.master. Carries X, Y, HSYNC, VSYNC,
//                DISPLAY, LINE_START, FRAME_START and the phase debug outputs.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10
) (
  input  logic               pixel_clk,
  input  logic               reset,
  vga_timing_gen_if.master   vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Last count value of each phase. Each FSM leaves its phase when the counter
  // reaches that value, so the state always matches the counter.
  localparam logic [X_WIDTH-1:0] H_ACT_END = X_WIDTH'(H_DISPLAY - 1);
  localparam logic [X_WIDTH-1:0] H_FP_END  = X_WIDTH'(H_DISPLAY + H_FRONT - 1);
  localparam logic [X_WIDTH-1:0] H_SYN_END = X_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [X_WIDTH-1:0] H_LAST    = X_WIDTH'(H_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] V_ACT_END = Y_WIDTH'(V_DISPLAY - 1);
  localparam logic [Y_WIDTH-1:0] V_FP_END  = Y_WIDTH'(V_DISPLAY + V_FRONT - 1);
  localparam logic [Y_WIDTH-1:0] V_SYN_END = Y_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [Y_WIDTH-1:0] V_LAST    = Y_WIDTH'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} v_state_t;

  h_state_t           h_state, h_state_next;
  v_state_t           v_state, v_state_next;
  logic [X_WIDTH-1:0] h_cnt, h_cnt_next;
  logic [Y_WIDTH-1:0] v_cnt, v_cnt_next;
  logic               h_wrap;

  always_comb begin
    h_wrap       = (h_cnt == H_LAST);
    h_cnt_next   = h_wrap ? '0 : h_cnt + X_WIDTH'(1);
    v_cnt_next   = v_cnt;
    h_state_next = h_state;
    v_state_next = v_state;

    case (h_state)
      H_ACT:   if (h_cnt == H_ACT_END) h_state_next = H_FP;
      H_FP:    if (h_cnt == H_FP_END)  h_state_next = H_SYN;
      H_SYN:   if (h_cnt == H_SYN_END) h_state_next = H_BP;
      H_BP:    if (h_wrap)             h_state_next = H_ACT;
      default:                         h_state_next = H_ACT;
    endcase

    // The vertical side moves only on the last pixel of a line. VSYNC
    // therefore changes on whole-line boundaries, together with X==0.
    if (h_wrap) begin
      v_cnt_next = (v_cnt == V_LAST) ? '0 : v_cnt + Y_WIDTH'(1);
      case (v_state)
        V_ACT:   if (v_cnt == V_ACT_END) v_state_next = V_FP;
        V_FP:    if (v_cnt == V_FP_END)  v_state_next = V_SYN;
        V_SYN:   if (v_cnt == V_SYN_END) v_state_next = V_BP;
        V_BP:    if (v_cnt == V_LAST)    v_state_next = V_ACT;
        default:                         v_state_next = V_ACT;
      endcase
    end
  end

  // Counter/FSM stage and output stage share one register process. The
  // outputs show the counter snapshot from one cycle earlier.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      h_state         <= H_ACT;
      v_state         <= V_ACT;
      vga.X           <= '0;
      vga.Y           <= '0;
      vga.HSYNC       <= ~H_SYNC_POL;
      vga.VSYNC       <= ~V_SYNC_POL;
      vga.DISPLAY     <= 1'b0;
      vga.LINE_START  <= 1'b0;
      vga.FRAME_START <= 1'b0;
    end else begin
      h_cnt           <= h_cnt_next;
      v_cnt           <= v_cnt_next;
      h_state         <= h_state_next;
      v_state         <= v_state_next;
      vga.X           <= h_cnt;
      vga.Y           <= v_cnt;
      vga.HSYNC       <= (h_state == H_SYN) ? H_SYNC_POL : ~H_SYNC_POL;
      vga.VSYNC       <= (v_state == V_SYN) ? V_SYNC_POL : ~V_SYNC_POL;
      vga.DISPLAY     <= (h_state == H_ACT) && (v_state == V_ACT);
      vga.LINE_START  <= (h_cnt == '0);
      vga.FRAME_START <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign vga.h_phase = h_state;
  assign vga.v_phase = v_state;

endmodule
